// File: rtl/lsu_pkg.sv
// Shared constants, state type and request-legality helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READ,
        WRITE
    } lsu_state_t;

    // Unsigned variants have no store form.
    function automatic logic f3_illegal(input logic i_we, input logic [2:0] i_f3);
        logic w_bad;
        case (i_f3)
            F3_B, F3_H, F3_W: w_bad = 1'b0;
            F3_BU, F3_HU:     w_bad = i_we;
            default:          w_bad = 1'b1;
        endcase
        return w_bad;
    endfunction

    function automatic logic misaligned(input logic [2:0] i_f3, input logic [1:0] i_lo);
        logic w_bad;
        case (i_f3)
            F3_H, F3_HU: w_bad = i_lo[0];
            F3_W:        w_bad = |i_lo;
            default:     w_bad = 1'b0;
        endcase
        return w_bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: sub-word load extract/extend and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mask;
    logic [31:0] w_data;

    always_comb begin
        w_byte = 8'(i_word >> {i_lane, 3'b000});
        w_half = 16'(i_word >> {i_lane[1], 4'b0000});

        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = i_word;
        endcase
    end

    // Bytes outside the mask keep their current memory contents.
    always_comb begin
        case (i_funct3)
            F3_B: begin
                w_mask = 32'h0000_00FF << {i_lane, 3'b000};
                w_data = {24'h0, i_wdata[7:0]} << {i_lane, 3'b000};
            end
            F3_H: begin
                w_mask = 32'h0000_FFFF << {i_lane[1], 4'b0000};
                w_data = {16'h0, i_wdata[15:0]} << {i_lane[1], 4'b0000};
            end
            default: begin
                w_mask = 32'hFFFF_FFFF;
                w_data = i_wdata;
            end
        endcase
        o_merged = (i_word & ~w_mask) | (w_data & w_mask);
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: request check, FSM sequencing loads and read-modify-write sub-word stores.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic        o_resp_err,
    output logic [31:0] o_resp_rdata,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_accept;
    logic        w_req_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_accept  = i_req_valid && (r_state == IDLE);
    assign w_req_err = f3_illegal(i_req_we, i_req_funct3)
                    || misaligned(i_req_funct3, i_req_addr[1:0])
                    || (i_req_addr >= MEM_BYTES);

    lsu_align u_align (
        .i_lane      (r_addr[1:0]),
        .i_funct3    (r_funct3),
        .i_word      (i_mem_rdata),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_req_err) begin
                    if (!i_req_we) begin
                        w_state_next = LOAD;
                    end else if (i_req_funct3 == F3_W) begin
                        w_state_next = WRITE;
                    end else begin
                        w_state_next = READ;
                    end
                end
            end
            LOAD:    w_state_next = IDLE;
            READ:    w_state_next = WRITE;
            WRITE:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Memory-side outputs depend only on state and latched address, so reset clears them at once.
    always_comb begin
        o_req_ready  = (r_state == IDLE);
        o_mem_we     = (r_state == WRITE);
        o_mem_addr   = {r_addr[31:2], 2'b00};
        o_mem_wdata  = o_mem_we ? r_merged : 32'h0;
        o_resp_valid = r_resp_valid;
        o_resp_err   = r_resp_err;
        o_resp_rdata = r_resp_rdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_merged     <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we     <= i_req_we;
                        r_funct3 <= i_req_funct3;
                        r_addr   <= i_req_addr;
                        r_wdata  <= i_req_wdata;
                        // Full-word stores skip the read, so their data is already final.
                        r_merged <= i_req_wdata;
                        if (w_req_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                end
                READ: begin
                    r_merged <= w_merged;
                end
                WRITE: begin
                    r_resp_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Latched direction is implied by state; kept for debug visibility.
    logic w_unused;
    assign w_unused = r_we;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a 64-word behavioural data memory.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    logic [31:0] we_addr = 32'h0;
    logic [31:0] mem [64];

    always #5 clk = ~clk;

    lsu #(.MEM_BYTES(256)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .o_resp_err   (resp_err),
        .o_resp_rdata (resp_rdata),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = mem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issues one request; lat counts falling edges after the accept edge until resp_valid.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic err,
                          output logic [31:0] rdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat   = 99;
        err   = 1'b0;
        rdata = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat   = c;
                err   = resp_err;
                rdata = resp_rdata;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                       input logic exp_err, input logic [31:0] exp_rdata, input int exp_we);
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          we0;
        we0 = we_cnt;
        do_req(we, f3, addr, wdata, lat, err, rdata);
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".err"}, {31'h0, err}, {31'h0, exp_err});
        check({tag, ".rdata"}, rdata, exp_rdata);
        check({tag, ".we_cycles"}, 32'(we_cnt - we0), 32'(exp_we));
    endtask

    initial begin
        int          t0;
        int          t1;
        int          nresp;
        int          we0;
        logic [31:0] d0;
        logic [31:0] d1;

        for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 | 32'(i);
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.ready", {31'h0, req_ready}, 32'h1);
        check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst.resp_err", {31'h0, resp_err}, 32'h0);
        check("rst.resp_rdata", resp_rdata, 32'h0);
        check("rst.mem_we", {31'h0, mem_we}, 32'h0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.mem_wdata", mem_wdata, 32'h0);

        run("sw", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 1);
        check("sw.we_addr", we_addr, 32'h10);
        check("sw.mem", mem[4], 32'hDEAD_BEEF);
        run("lw", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 0);

        run("sb", 1'b1, 3'b000, 32'h11, 32'hFFFF_FFA5, 3, 1'b0, 32'h0, 1);
        check("sb.we_addr", we_addr, 32'h10);
        check("sb.mem", mem[4], 32'hDEAD_A5EF);
        run("lb", 1'b0, 3'b000, 32'h11, 32'h0, 2, 1'b0, 32'hFFFF_FFA5, 0);
        run("lbu", 1'b0, 3'b100, 32'h11, 32'h0, 2, 1'b0, 32'h0000_00A5, 0);

        run("sh", 1'b1, 3'b001, 32'h12, 32'h1234_8001, 3, 1'b0, 32'h0, 1);
        check("sh.mem", mem[4], 32'h8001_A5EF);
        run("lh", 1'b0, 3'b001, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF_8001, 0);
        run("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 2, 1'b0, 32'h0000_8001, 0);
        run("lh_lo", 1'b0, 3'b001, 32'h10, 32'h0, 2, 1'b0, 32'hFFFF_A5EF, 0);
        run("lb_b3", 1'b0, 3'b000, 32'h13, 32'h0, 2, 1'b0, 32'hFFFF_FF80, 0);

        run("err_lw_mis", 1'b0, 3'b010, 32'h12, 32'h0, 1, 1'b1, 32'h0, 0);
        run("err_sh_mis", 1'b1, 3'b001, 32'h13, 32'h0000_5555, 1, 1'b1, 32'h0, 0);
        run("err_range", 1'b0, 3'b000, 32'h100, 32'h0, 1, 1'b1, 32'h0, 0);
        run("err_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'h0, 0);
        run("err_st_100", 1'b1, 3'b100, 32'h10, 32'h0000_0011, 1, 1'b1, 32'h0, 0);
        check("err.mem", mem[4], 32'h8001_A5EF);

        // Held valid: second LW is taken on the edge where the first response is high.
        nresp = 0;
        t0 = 0;
        t1 = 0;
        d0 = 32'h0;
        d1 = 32'h0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        @(posedge clk);
        #1 req_addr = 32'h14;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (nresp == 0) begin
                    t0 = k;
                    d0 = resp_rdata;
                    check("b2b.ready_at_resp", {31'h0, req_ready}, 32'h1);
                end else begin
                    t1 = k;
                    d1 = resp_rdata;
                end
                nresp++;
                if (nresp == 1) begin
                    @(posedge clk);
                    #1 req_valid = 1'b0;
                end
            end
        end
        check("b2b.count", 32'(nresp), 32'd2);
        check("b2b.first_lat", 32'(t0), 32'd2);
        check("b2b.spacing", 32'(t1 - t0), 32'd2);
        check("b2b.data0", d0, 32'h8001_A5EF);
        check("b2b.data1", d1, 32'hC000_0005);

        // Reset while the SB is in its read phase.
        we0 = we_cnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h20;
        req_wdata  = 32'h0000_0077;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rstmid.ready", {31'h0, req_ready}, 32'h1);
        check("rstmid.mem_we", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        nresp = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        check("rstmid.no_resp", 32'(nresp), 32'd0);
        check("rstmid.no_write", 32'(we_cnt - we0), 32'd0);
        check("rstmid.mem", mem[8], 32'hC000_0008);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and `data_mem`. Accepts one load or store per handshake, enforces RV32I natural alignment and range, and extracts/sign-extends sub-word loads. Sub-word stores are done as read-modify-write because `data_mem` only writes full 32-bit words. `data_mem` is always driven with word-aligned addresses.

## Interface
- `MEM_BYTES`, 256: data memory size in bytes; any power of two ≥ 4.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept; high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_err`  out  1  request rejected; no memory write occurred
- `resp_rdata`  out  32  load result; 0 for stores and errors
- `mem_addr`  out  32  to `data_mem.address`; always `{addr[31:2],2'b00}`
- `mem_we`  out  1  to `data_mem.WRITE_ENABLE`
- `mem_wdata`  out  32  to `data_mem.WRITE_DATA`
- `mem_rdata`  in  32  from `data_mem.READ_DATA`; combinational

## Operation
- Accept when `req_valid && req_ready` at a rising edge. Latch `we`, `funct3`, `addr`, `wdata`.
- Error if any of these holds; response goes out next cycle with `resp_err=1` and no memory cycle:
  - illegal funct3: 011, 11x, or store with 1xx
  - H/HU with `addr[0]`
  - W with `addr[1:0]≠0`
  - `addr ≥ MEM_BYTES`
- FSM states:
  - IDLE: `req_ready=1`. Legal load → LOAD. SW → WRITE. SB/SH → READ.
  - LOAD: extract from `mem_rdata` into `resp_rdata`, then → IDLE.
  - READ: merge `wdata` into `mem_rdata` in a holding register, then → WRITE.
  - WRITE: `mem_we=1`, `mem_wdata` = merged word (SW: `wdata`), then → IDLE.
- Load extraction uses byte lane `k=addr[1:0]`, halfword lane `h=addr[1]`:
  - B: sign-extend `rdata[8k+:8]`
  - BU: zero-extend `rdata[8k+:8]`
  - H/HU: `rdata[16h+:16]`, sign- or zero-extended
  - W: `rdata`
- Store merge:
  - SB replaces `word[8k+:8]` with `wdata[7:0]`.
  - SH replaces `word[16h+:16]` with `wdata[15:0]`.
  - All other bytes are preserved.
- `resp_valid` pulses for one cycle on every completion, load or store. The consumer has no backpressure and must take the response.

## Timing
- Reset values: state IDLE, `req_ready=1`, every other output 0.
- `mem_we` and `mem_addr` decode from state and latched address, so async reset drops `mem_we` immediately.
- Latency from accept edge N to `resp_valid` high:
  - error: cycle N+1
  - LW/LH/LB/SW: cycle N+2
  - SB/SH: cycle N+3
- `mem_we` is high exactly one cycle per store, in WRITE only, and never for loads or errors.
- The response cycle coincides with IDLE, so the next request is accepted on the same edge that `resp_valid` is high. Sustained throughput: one load per 2 cycles, one sub-word store per 3 cycles.
- Error requests finish in IDLE, so back-to-back errors are accepted every cycle.
- Reset mid-operation (LOAD/READ/WRITE) aborts the operation: no write, no response, `req_ready=1` at once.

## Structure
- `lsu_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`)
  - state enum `lsu_state_t` {IDLE, LOAD, READ, WRITE}
- One combinational sub-module, `lsu_align`: load extract/extend and store merge, inputs lane + funct3.
- FSM, latches and error check stay in `lsu`.

## Test plan
- SW `0xDEADBEEF` @0x10, then LW @0x10 → `resp_rdata=0xDEADBEEF`, each response 2 cycles after accept; `mem_we` high 1 cycle with `mem_addr=0x10`.
- SB `0xA5` @0x11 → word 0x10 becomes `0xDEADA5EF`, response 3 cycles after accept. Then LB @0x11 → `0xFFFFFFA5`, and LBU @0x11 → `0x000000A5`.
- SH `0x8001` @0x12 → word `0x8001A5EF`. Then LH @0x12 → `0xFFFF8001`, and LHU @0x12 → `0x00008001`.
- Each of the following gives `resp_err=1` one cycle after accept, `mem_we` never asserted, memory unchanged:
  - LW @0x12
  - SH @0x13
  - LB @0x100 (MEM_BYTES=256)
  - funct3 011
  - store funct3 100
- Assert `rst` during READ of an SB → `mem_we` stays 0, `req_ready=1` immediately, no `resp_valid`, target word unchanged.
- Hold `req_valid` with LW then LW back-to-back → second accepted on the edge where the first `resp_valid` is high; responses 2 cycles apart, data correct.
